// File: rtl/reservatorio_agua.sv
// Water-reservoir level tracker: drains one unit per pumping cycle, refills on a
// user request, flags dry pumping and keeps a saturating consumption total.
module reservatorio_agua #(
  parameter int unsigned CAPACIDADE   = 12,
  parameter int unsigned NIVEL_MIN    = 2,
  parameter int unsigned NIVEL_RESET  = 12,
  parameter int unsigned FALHA_CICLOS = 3,
  parameter int unsigned NIVEL_W      = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               Power,
  input  logic               BombaAgua,
  input  logic               botao_encher,
  output logic               Reservatorio,
  output logic               refill,
  output logic [NIVEL_W-1:0] nivel,
  output logic               erro_seco,
  output logic [7:0]         total_consumido,
  output logic [1:0]         estado
);

  typedef enum logic [1:0] {
    NORMAL = 2'b00,
    BAIXO  = 2'b01,
    ENCHER = 2'b10
  } estado_t;

  localparam int unsigned CW = (FALHA_CICLOS < 2) ? 1 : $clog2(FALHA_CICLOS + 1);
  localparam logic [NIVEL_W-1:0] CAP     = NIVEL_W'(CAPACIDADE);
  localparam logic [NIVEL_W-1:0] MINIMO  = NIVEL_W'(NIVEL_MIN);
  localparam logic [NIVEL_W-1:0] INICIAL = NIVEL_W'(NIVEL_RESET);
  localparam logic [CW-1:0]      FALHA   = CW'(FALHA_CICLOS);
  localparam estado_t ESTADO_RST = (NIVEL_RESET >= NIVEL_MIN) ? NORMAL : BAIXO;

  estado_t state, stateNext;
  logic [NIVEL_W-1:0] nivelNext;
  logic [CW-1:0] dryCnt, dryCntNext;
  logic botaoQ, inicio, drain, fill, dry, dryHit, entering, refillNext;

  assign estado = state;

  always_comb begin
    inicio     = botao_encher & ~botaoQ;
    drain      = Power & BombaAgua & (nivel != '0);
    fill       = Power & (state == ENCHER) & (nivel < CAP);
    dry        = Power & BombaAgua & (nivel == '0);
    nivelNext  = nivel;
    dryCntNext = '0;
    entering   = 1'b0;
    refillNext = 1'b0;
    stateNext  = state;

    if (drain && !fill)
      nivelNext = nivel - NIVEL_W'(1);
    else if (fill && !drain)
      nivelNext = nivel + NIVEL_W'(1);

    if (dry)
      dryCntNext = (dryCnt >= FALHA) ? FALHA : dryCnt + CW'(1);
    dryHit = dry && (dryCntNext == FALHA);

    // With Power=0 nivelNext equals nivel, so the by-level fallback covers the abort.
    case (state)
      NORMAL, BAIXO: begin
        if (Power && inicio) begin
          stateNext = ENCHER;
          entering  = 1'b1;
        end else begin
          stateNext = (nivelNext >= MINIMO) ? NORMAL : BAIXO;
        end
      end
      ENCHER: begin
        if (!Power) begin
          stateNext = (nivelNext >= MINIMO) ? NORMAL : BAIXO;
        end else if (nivelNext == CAP) begin
          stateNext  = NORMAL;
          refillNext = 1'b1;
        end
      end
      default: stateNext = BAIXO;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ESTADO_RST;
      nivel           <= INICIAL;
      Reservatorio    <= (NIVEL_RESET >= NIVEL_MIN);
      refill          <= 1'b0;
      erro_seco       <= 1'b0;
      total_consumido <= '0;
      dryCnt          <= '0;
      botaoQ          <= 1'b0;
    end else begin
      state        <= stateNext;
      nivel        <= nivelNext;
      Reservatorio <= (nivelNext >= MINIMO);
      refill       <= refillNext;
      dryCnt       <= dryCntNext;
      botaoQ       <= botao_encher;
      if (drain && total_consumido != '1)
        total_consumido <= total_consumido + 8'd1;
      // A fill request clears the alarm even if the same cycle would latch it.
      if (entering)
        erro_seco <= 1'b0;
      else if (dryHit)
        erro_seco <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reservatorio_agua.sv
// Bench for reservatorio_agua: directed scenarios with literal checks plus
// randomized traffic compared every cycle against a level/flag model.
module tb_reservatorio_agua;

  localparam int CAP   = 12;
  localparam int NMIN  = 2;
  localparam int NRST  = 12;
  localparam int FALHA = 3;
  localparam int NW    = 4;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic Power = 1'b0;
  logic BombaAgua = 1'b0;
  logic botao_encher = 1'b0;
  logic Reservatorio, refill, erro_seco;
  logic [NW-1:0] nivel;
  logic [7:0] total_consumido;
  logic [1:0] estado;

  int nCmp = 0;
  int nBad = 0;
  bit compEn = 1'b0;

  // Model state: tank contents, whether a fill is in progress, and counters.
  int  mLevel, mTotal, mDry;
  bit  mFilling, mErr, mRefill, mBtnPrev;

  reservatorio_agua #(
    .CAPACIDADE(CAP), .NIVEL_MIN(NMIN), .NIVEL_RESET(NRST),
    .FALHA_CICLOS(FALHA), .NIVEL_W(NW)
  ) dut (
    .clock(clock), .reset_n(reset_n), .Power(Power), .BombaAgua(BombaAgua),
    .botao_encher(botao_encher), .Reservatorio(Reservatorio), .refill(refill),
    .nivel(nivel), .erro_seco(erro_seco), .total_consumido(total_consumido),
    .estado(estado)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    nCmp++;
    if (act != exp) begin
      nBad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int expEstado();
    if (mFilling) return 2;
    return (mLevel >= NMIN) ? 0 : 1;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mLevel = NRST; mTotal = 0; mDry = 0;
      mFilling = 0; mErr = 0; mRefill = 0; mBtnPrev = 0;
    end else begin
      bit press;
      press = botao_encher && !mBtnPrev;
      mBtnPrev = botao_encher;
      mRefill = 0;
      if (Power) begin
        int d, f, old;
        old = mLevel;
        d = (BombaAgua && old > 0) ? 1 : 0;
        f = (mFilling && old < CAP) ? 1 : 0;
        mLevel = old - d + f;
        mTotal = (mTotal + d > 255) ? 255 : mTotal + d;
        mDry = (BombaAgua && old == 0) ? ((mDry + 1 > FALHA) ? FALHA : mDry + 1) : 0;
        if (mDry >= FALHA) mErr = 1;
        if (mFilling) begin
          if (mLevel == CAP) begin
            mRefill = 1;
            mFilling = 0;
          end
        end else if (press) begin
          mFilling = 1;
          mErr = 0;
        end
      end else begin
        mDry = 0;
        mFilling = 0;
      end
    end
  end

  always @(negedge clock) begin
    if (compEn) begin
      chk("nivel", int'(nivel), mLevel);
      chk("Reservatorio", int'(Reservatorio), (mLevel >= NMIN) ? 1 : 0);
      chk("refill", int'(refill), int'(mRefill));
      chk("erro_seco", int'(erro_seco), int'(mErr));
      chk("total_consumido", int'(total_consumido), mTotal);
      chk("estado", int'(estado), expEstado());
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  initial begin
    tick(2);
    #1 reset_n = 1'b1;
    Power = 1'b1;
    compEn = 1'b1;
    tick(1);
    chk("rst_nivel", int'(nivel), 12);
    chk("rst_estado", int'(estado), 0);
    chk("rst_reserv", int'(Reservatorio), 1);

    // Drain 10 units, then one more crosses the minimum.
    BombaAgua = 1'b1;
    tick(10);
    chk("t1_nivel2", int'(nivel), 2);
    chk("t1_total10", int'(total_consumido), 10);
    chk("t1_reserv1", int'(Reservatorio), 1);
    tick(1);
    chk("t1_nivel1", int'(nivel), 1);
    chk("t1_reserv0", int'(Reservatorio), 0);
    chk("t1_baixo", int'(estado), 1);

    // Held button gives one fill; 11 cycles to full.
    BombaAgua = 1'b0;
    botao_encher = 1'b1;
    tick(1);
    chk("t2_encher", int'(estado), 2);
    chk("t2_nivel_entry", int'(nivel), 1);
    tick(3);
    botao_encher = 1'b0;
    tick(7);
    chk("t2_nivel11", int'(nivel), 11);
    chk("t2_norefill", int'(refill), 0);
    tick(1);
    chk("t2_nivel12", int'(nivel), 12);
    chk("t2_refill", int'(refill), 1);
    chk("t2_normal", int'(estado), 0);
    tick(1);
    chk("t2_refill_off", int'(refill), 0);

    // Pump during fill stalls the level.
    BombaAgua = 1'b1;
    tick(7);
    BombaAgua = 1'b0;
    botao_encher = 1'b1;
    tick(1);
    botao_encher = 1'b0;
    chk("t3_entry5", int'(nivel), 5);
    BombaAgua = 1'b1;
    tick(3);
    chk("t3_stall5", int'(nivel), 5);
    chk("t3_total21", int'(total_consumido), 21);
    BombaAgua = 1'b0;
    tick(6);
    chk("t3_nivel11", int'(nivel), 11);
    tick(1);
    chk("t3_refill", int'(refill), 1);

    // Dry running.
    BombaAgua = 1'b1;
    tick(12);
    chk("t4_nivel0", int'(nivel), 0);
    chk("t4_total33", int'(total_consumido), 33);
    tick(2);
    chk("t4_err_early", int'(erro_seco), 0);
    tick(1);
    chk("t4_err_set", int'(erro_seco), 1);
    chk("t4_total_hold", int'(total_consumido), 33);
    BombaAgua = 1'b0;
    botao_encher = 1'b1;
    tick(1);
    botao_encher = 1'b0;
    chk("t4_err_clr", int'(erro_seco), 0);
    chk("t4_encher", int'(estado), 2);
    tick(7);
    chk("t5_nivel7", int'(nivel), 7);

    // Power loss aborts the fill.
    Power = 1'b0;
    tick(5);
    chk("t5_hold7", int'(nivel), 7);
    chk("t5_abort", int'(estado), 0);
    Power = 1'b1;
    tick(1);
    chk("t5_still7", int'(nivel), 7);
    chk("t5_normal", int'(estado), 0);

    // Asynchronous reset mid-fill.
    botao_encher = 1'b1;
    tick(1);
    botao_encher = 1'b0;
    tick(2);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_nivel", int'(nivel), 12);
    chk("t6_rst_refill", int'(refill), 0);
    chk("t6_rst_err", int'(erro_seco), 0);
    chk("t6_rst_total", int'(total_consumido), 0);
    #2 reset_n = 1'b1;
    tick(1);

    // 300 drained units saturate at 255.
    for (int k = 0; k < 25; k++) begin
      BombaAgua = 1'b1;
      tick(12);
      BombaAgua = 1'b0;
      botao_encher = 1'b1;
      tick(1);
      botao_encher = 1'b0;
      tick(13);
    end
    chk("t6_sat255", int'(total_consumido), 255);

    // Randomized traffic with rare asynchronous resets.
    for (int c = 0; c < 3000; c++) begin
      Power = ($urandom_range(0, 9) != 0);
      BombaAgua = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) botao_encher = ~botao_encher;
      if ($urandom_range(0, 499) == 0) begin
        reset_n = 1'b0;
        #1 reset_n = 1'b1;
      end
      tick(1);
    end

    compEn = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule

// File: doc/reservatorio_agua.md
Name: reservatorio_agua

Overview:
- Water-reservoir level tracker feeding the coffee-machine state controller; produces its `Reservatorio` and `refill` inputs.
- Consumes that controller's `BombaAgua` output.
- Models tank level as a unit counter: pumping drains one unit per clock, a user fill request tops the tank back up.
- Also raises a dry-run alarm and keeps a saturating total-consumption count.

Parameters:
- CAPACIDADE, 12: full-tank level in units (1..2^NIVEL_W-1).
- NIVEL_MIN, 2: minimum level for `Reservatorio`=1 (1..CAPACIDADE).
- NIVEL_RESET, 12: level loaded on reset (0..CAPACIDADE).
- FALHA_CICLOS, 3: consecutive dry-pump cycles that set `erro_seco` (>=1).
- NIVEL_W, 4: width of the level counter.

Ports:
- clock  in  1  system clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- Power  in  1  machine on; 0 freezes level and aborts filling
- BombaAgua  in  1  pump running (from state controller)
- botao_encher  in  1  user fill request, level signal, rising-edge detected internally
- Reservatorio  out  1  registered; 1 when nivel >= NIVEL_MIN
- refill  out  1  one-cycle pulse when a fill completes (nivel reaches CAPACIDADE)
- nivel  out  NIVEL_W  current level
- erro_seco  out  1  latched dry-run alarm
- total_consumido  out  8  units drained since reset, saturates at 255
- estado  out  2  FSM state code for display

Behaviour:
Reset (async, reset_n=0):
- nivel=NIVEL_RESET; Reservatorio=(NIVEL_RESET>=NIVEL_MIN); refill=0; erro_seco=0; total_consumido=0; dry counter=0.
- Edge-detect register=0.
- estado = NORMAL if Reservatorio else BAIXO.
- Release is seen on the next rising clock.

Edge detect:
- `inicio` = botao_encher & ~botao_q; botao_q registered every cycle, including when Power=0.

States (estado code):
- NORMAL=00: nivel >= NIVEL_MIN.
- BAIXO=01: nivel < NIVEL_MIN.
- ENCHER=10: filling.
- Code 11 unused; if reached, go to BAIXO next cycle.

Per cycle with Power=1:
- Drain `d` = BombaAgua & (nivel>0). Fill `f` = (state==ENCHER) & (nivel<CAPACIDADE).
- nivel_next = nivel - d + f. If both d and f, nivel is unchanged.
- total_consumido increments when d=1, saturating at 255.
- NORMAL or BAIXO + `inicio` -> ENCHER. `erro_seco` clears on this transition.
- NORMAL/BAIXO without `inicio` -> NORMAL if nivel_next >= NIVEL_MIN, else BAIXO.
- ENCHER: when nivel_next == CAPACIDADE (including entering ENCHER when already full):
  - refill=1 for exactly that cycle (registered, coincident with nivel update).
  - next state NORMAL.
  - `inicio` while already in ENCHER is ignored.
- Reservatorio is registered as (nivel_next >= NIVEL_MIN), so it always matches nivel on the same edge.

Power=0:
- nivel, total_consumido and erro_seco hold; dry counter clears; refill=0.
- ENCHER aborts to NORMAL/BAIXO by current nivel with no refill pulse.
- BombaAgua is ignored.

Dry-run detection:
- Counter increments each cycle BombaAgua=1 with nivel==0 and Power=1; otherwise it clears.
- On reaching FALHA_CICLOS, erro_seco=1 (latched); the counter saturates.
- erro_seco clears only on reset or entry into ENCHER.

Boundaries:
- nivel never underflows below 0 or exceeds CAPACIDADE.
- Pumping at 0 leaves nivel at 0 and does not increment total_consumido.
- refill is never asserted in two consecutive cycles.

Test Plan:
1. Reset with defaults, Power=1, BombaAgua=1 for 10 cycles -> nivel 12→2, Reservatorio stays 1, total_consumido=10; one more cycle -> nivel=1, Reservatorio=0 on the same edge, estado=01.
2. From nivel=1 (BAIXO), pulse botao_encher high 4 cycles -> one ENCHER entry, nivel rises 1/cycle to 12 after 11 cycles, refill=1 exactly on the cycle nivel becomes 12, then estado=00, refill=0.
3. In ENCHER at nivel=5 with BombaAgua=1 for 3 cycles -> nivel stays 5, total_consumido +3; BombaAgua=0 -> fill resumes to 12 with a single refill pulse.
4. Drain to 0, keep BombaAgua=1 -> nivel stays 0, total_consumido unchanged, erro_seco=1 after the 3rd dry cycle; botao_encher edge -> erro_seco=0 the next edge, filling starts.
5. In ENCHER at nivel=7, drop Power for 5 cycles -> nivel holds 7, no refill pulse, estado=00; Power=1 without botao -> stays NORMAL at 7.
6. Assert reset_n=0 mid-fill asynchronously (between clock edges) -> outputs immediately go to reset values (nivel=12, refill=0, erro_seco=0); total_consumido saturation check: 300 drain units total -> reads 255.
